// File: rtl/ro_puf_resp_gen.sv
// Ring-oscillator PUF response generator: races RESP_BITS selected oscillator
// pairs over a timed window each and returns one comparison bit per pair.
module ro_puf_resp_gen #(
  parameter int NUM_RO    = 8,
  parameter int SEL_W     = 3,
  parameter int CNT_W     = 8,
  parameter int WIN_W     = 16,
  parameter int RESP_BITS = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_RO-1:0]              ro_in,
  input  logic                           start,
  input  logic [2*SEL_W*RESP_BITS-1:0]   challenge,
  input  logic [WIN_W-1:0]               window,
  output logic                           busy,
  output logic                           done,
  output logic [RESP_BITS-1:0]           response,
  output logic [CNT_W-1:0]               count_1,
  output logic [CNT_W-1:0]               count_2,
  output logic                           tie,
  output logic                           sat
);

  localparam int K_W  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int PAD  = 1 << SEL_W;
  localparam logic [K_W-1:0]   K_LAST = K_W'(RESP_BITS - 1);
  localparam logic [CNT_W-1:0] C_MAX  = '1;

  typedef enum logic [2:0] {IDLE, CLEAR, COUNT, COMPARE, DONE} state_t;
  state_t state, nxt;

  logic [NUM_RO-1:0] s1, s2, s3, edges;
  logic [PAD-1:0]    edges_pad;
  logic [RESP_BITS-1:0][2*SEL_W-1:0] pairs;
  logic [SEL_W-1:0]  sel1, sel2;
  logic [K_W-1:0]    k;
  logic [WIN_W-1:0]  win_q, timer;
  logic [RESP_BITS-1:0] shadow;
  logic              e1, e2;

  // Two flops resynchronise the free-running oscillators; the third gives edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= ro_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edges = s2 & ~s3;

  // Unpopulated select codes land on zero padding and never count.
  always_comb begin
    edges_pad = '0;
    edges_pad[NUM_RO-1:0] = edges;
  end

  assign e1 = edges_pad[sel1];
  assign e2 = edges_pad[sel2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = CLEAR;
      CLEAR:   nxt = COUNT;
      COUNT:   if (timer <= WIN_W'(1)) nxt = COMPARE;
      COMPARE: nxt = (k == K_LAST) ? DONE : CLEAR;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign busy = (state == CLEAR) || (state == COUNT) || (state == COMPARE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pairs    <= '0;
      win_q    <= '0;
      timer    <= '0;
      sel1     <= '0;
      sel2     <= '0;
      k        <= '0;
      count_1  <= '0;
      count_2  <= '0;
      shadow   <= '0;
      response <= '0;
      tie      <= 1'b0;
      sat      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          pairs <= challenge;
          win_q <= (window == '0) ? WIN_W'(1) : window;
          k     <= '0;
          tie   <= 1'b0;
          sat   <= 1'b0;
        end
        CLEAR: begin
          count_1 <= '0;
          count_2 <= '0;
          sel1    <= pairs[k][2*SEL_W-1:SEL_W];
          sel2    <= pairs[k][SEL_W-1:0];
          timer   <= win_q;
        end
        COUNT: begin
          timer <= timer - WIN_W'(1);
          if (e1 && count_1 != C_MAX) begin
            count_1 <= count_1 + CNT_W'(1);
            if (count_1 == C_MAX - CNT_W'(1)) sat <= 1'b1;
          end
          if (e2 && count_2 != C_MAX) begin
            count_2 <= count_2 + CNT_W'(1);
            if (count_2 == C_MAX - CNT_W'(1)) sat <= 1'b1;
          end
        end
        COMPARE: begin
          shadow[k] <= (count_1 > count_2);
          if (count_1 == count_2) tie <= 1'b1;
          if (k != K_LAST) k <= k + K_W'(1);
        end
        DONE: response <= shadow;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_puf_resp_gen.sv
// Directed bench for ro_puf_resp_gen with six free-running oscillators of known period.
module tb_ro_puf_resp_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  ro_in;
  logic        start;
  logic [23:0] challenge;
  logic [15:0] window;
  logic        busy, done, tie, sat;
  logic [3:0]  response;
  logic [7:0]  count_1, count_2;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int cyc;
  int dc0;
  logic busy1;

  logic r0 = 1'b0, r1 = 1'b0, r2 = 1'b0, r3 = 1'b0, r4 = 1'b0, r5 = 1'b0;

  ro_puf_resp_gen #(.NUM_RO(6), .SEL_W(3), .CNT_W(8), .WIN_W(16), .RESP_BITS(4)) dut (
    .clk(clk), .reset(reset), .ro_in(ro_in), .start(start), .challenge(challenge),
    .window(window), .busy(busy), .done(done), .response(response),
    .count_1(count_1), .count_2(count_2), .tie(tie), .sat(sat)
  );

  always #5 clk = ~clk;

  // Oscillator periods in clk cycles: 4, 6, 8, 10, 12, 14; phase offset keeps them off clk edges.
  initial begin #3; forever #20 r0 = ~r0; end
  initial begin #3; forever #30 r1 = ~r1; end
  initial begin #3; forever #40 r2 = ~r2; end
  initial begin #3; forever #50 r3 = ~r3; end
  initial begin #3; forever #60 r4 = ~r4; end
  initial begin #3; forever #70 r5 = ~r5; end
  assign ro_in = {r5, r4, r3, r2, r1, r0};

  always @(negedge clk) if (done) done_cnt++;

  function automatic logic [5:0] pr(input int a, input int b);
    logic [2:0] sa, sb;
    sa = 3'(a);
    sb = 3'(b);
    return {sa, sb};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a run, returns the cycle of the done pulse (cycle 0 = start sampled), -1 on timeout.
  task automatic run(input logic [23:0] ch, input logic [15:0] win, input bit poke,
                     output int c, output logic b1);
    @(negedge clk);
    challenge = ch;
    window    = win;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    c  = -1;
    b1 = 1'b0;
    for (int n = 1; n <= 6000; n++) begin
      @(negedge clk);
      if (n == 1) b1 = busy;
      if (poke && n == 10) begin
        start     = 1'b1;
        challenge = {pr(1,0), pr(1,0), pr(1,0), pr(1,0)};
      end
      if (poke && n == 11) start = 1'b0;
      if (done) begin
        c = n;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"},     32'(busy),     32'd0);
    chk({tag, ".done"},     32'(done),     32'd0);
    chk({tag, ".response"}, 32'(response), 32'd0);
    chk({tag, ".count_1"},  32'(count_1),  32'd0);
    chk({tag, ".count_2"},  32'(count_2),  32'd0);
    chk({tag, ".tie"},      32'(tie),      32'd0);
    chk({tag, ".sat"},      32'(sat),      32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; challenge = '0; window = '0;
    repeat (4) @(negedge clk);
    chk_zero("rst_held");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("rst_rel");

    // All pairs (0,1): RO0 gives exactly 5 edges per 20 cycles, RO1 3 or 4.
    run({pr(0,1), pr(0,1), pr(0,1), pr(0,1)}, 16'd20, 1'b0, cyc, busy1);
    chk("basic.busy_c1", 32'(busy1), 32'd1);
    chk("basic.cycles", 32'(cyc), 32'd89);
    chk("basic.cnt1_range", 32'(count_1 >= 8'd4 && count_1 <= 8'd6), 32'd1);
    chk("basic.cnt2_range", 32'(count_2 >= 8'd2 && count_2 <= 8'd4), 32'd1);
    chk("basic.response", 32'(response), 32'hF);
    chk("basic.busy_after", 32'(busy), 32'd0);

    run({pr(1,0), pr(0,1), pr(1,0), pr(0,1)}, 16'd20, 1'b0, cyc, busy1);
    chk("alt.cycles", 32'(cyc), 32'd89);
    chk("alt.response", 32'(response), 32'h5);
    chk("alt.tie", 32'(tie), 32'd0);
    chk("alt.sat", 32'(sat), 32'd0);

    // Pair 0 equal selects -> tie; pair 3 selects absent RO7 against RO3 (exactly 2 edges).
    run({pr(7,3), pr(0,1), pr(0,1), pr(2,2)}, 16'd20, 1'b0, cyc, busy1);
    chk("tie.response", 32'(response), 32'h6);
    chk("tie.tie", 32'(tie), 32'd1);
    chk("tie.cnt1_absent", 32'(count_1), 32'd0);
    chk("tie.cnt2", 32'(count_2), 32'd2);

    // 1200-cycle window: RO0 would reach 300, RO1 200.
    run({pr(0,1), pr(0,1), pr(0,1), pr(0,1)}, 16'd1200, 1'b0, cyc, busy1);
    chk("sat.cycles", 32'(cyc), 32'd4809);
    chk("sat.cnt1", 32'(count_1), 32'd255);
    chk("sat.cnt2", 32'(count_2), 32'd200);
    chk("sat.flag", 32'(sat), 32'd1);
    chk("sat.tie_cleared", 32'(tie), 32'd0);
    chk("sat.response", 32'(response), 32'hF);

    run({pr(0,1), pr(0,1), pr(0,1), pr(0,1)}, 16'd0, 1'b0, cyc, busy1);
    chk("win0.cycles", 32'(cyc), 32'd13);
    chk("win0.sat_cleared", 32'(sat), 32'd0);

    // A second start mid-run, with a different challenge on the bus, must change nothing.
    dc0 = done_cnt;
    run({pr(1,0), pr(0,1), pr(1,0), pr(0,1)}, 16'd20, 1'b1, cyc, busy1);
    repeat (40) @(negedge clk);
    chk("poke.cycles", 32'(cyc), 32'd89);
    chk("poke.response", 32'(response), 32'h5);
    chk("poke.done_once", 32'(done_cnt - dc0), 32'd1);
    chk("poke.busy", 32'(busy), 32'd0);

    // Reset mid-COUNT.
    @(negedge clk);
    challenge = {pr(0,1), pr(0,1), pr(0,1), pr(0,1)};
    window = 16'd20;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid.busy_before", 32'(busy), 32'd1);
    dc0 = done_cnt;
    reset = 1'b1;
    #1;
    chk_zero("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    repeat (120) @(negedge clk);
    chk("mid.no_done", 32'(done_cnt - dc0), 32'd0);
    chk("mid.response", 32'(response), 32'd0);
    chk("mid.busy_after", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
